uart_tx_engine: RTL and testbench

UART_TX_ENGINE -- requirements
Module: uart_tx_engine

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_bit_timer.sv | 31 +++
 rtl/uart_tx_engine.sv | 113 +++++++++++
 tb/tb_uart_tx_engine.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants, state encoding and bit-time divisor helpers for the UART transmitter.
package uart_pkg;

  localparam int FRAME_BITS = 11;
  localparam int BIT_CNT_W  = 4;
  localparam int DIV_W      = 24;
  localparam int NUM_RATES  = 16;

  // Selects 12..15 alias the fastest rate.
  localparam int unsigned BAUD_RATE [NUM_RATES] = '{
    300, 1200, 2400, 4800, 9600, 19200, 38400, 57600,
    115200, 230400, 460800, 921600, 921600, 921600, 921600, 921600
  };

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_e;

  function automatic logic [DIV_W-1:0] bit_divisor(input longint clk_hz, input longint rate);
    longint q;
    q = (clk_hz + rate / 2) / rate;
    return q[DIV_W-1:0];
  endfunction

  function automatic logic [NUM_RATES*DIV_W-1:0] divisor_table(input longint clk_hz);
    logic [NUM_RATES*DIV_W-1:0] t;
    t = '0;
    for (int i = 0; i < NUM_RATES; i++) begin
      t[i*DIV_W +: DIV_W] = bit_divisor(clk_hz, longint'(BAUD_RATE[i]));
    end
    return t;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Divisor counter: emits a one-cycle btu_o pulse on the last clock of every bit-time.
module uart_bit_timer
  import uart_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             btu_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign btu_o = !clr_i && (cnt_q == (div_i - DIV_W'(1)));

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (clr_i || btu_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: 11-bit frames, LSB first, optional parity under UART_TX_PARITY_EN.
// Handshake: load is taken only while txrdy is high; the start bit appears on the following edge.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] din,
  input  logic [3:0] baud_sel,
  input  logic       eight,
  input  logic       pen,
  input  logic       ohel,
  output logic       tx,
  output logic       txrdy,
  output tx_state_e  state_o
);

  localparam logic [NUM_RATES*DIV_W-1:0] DIV_TABLE = divisor_table(longint'(CLK_HZ));

  tx_state_e            state_q, state_d;
  logic [9:0]           shreg_q, shreg_d;
  logic                 tx_q, tx_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [3:0]           baud_q, baud_d;
  logic [DIV_W-1:0]     div;
  logic                 btu;
  logic                 pen_eff;
  logic                 par_bit;
  logic                 bit8;
  logic                 bit9;

  assign div     = DIV_TABLE[int'(baud_q)*DIV_W +: DIV_W];
  assign tx      = tx_q;
  assign txrdy   = (state_q == ST_IDLE);
  assign state_o = state_q;

`ifdef UART_TX_PARITY_EN
  assign pen_eff = pen;
  assign par_bit = (^(din & (eight ? 8'hFF : 8'h7F))) ^ ohel;
`else
  logic cfg_unused;
  assign cfg_unused = pen ^ ohel;
  assign pen_eff    = 1'b0;
  assign par_bit    = 1'b1;
`endif

  assign bit8 = eight ? din[7] : (pen_eff ? par_bit : 1'b1);
  assign bit9 = (eight && pen_eff) ? par_bit : 1'b1;

  uart_bit_timer u_bit_timer (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (state_q != ST_SEND),
    .div_i (div),
    .btu_o (btu)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    tx_d      = tx_q;
    bit_cnt_d = bit_cnt_q;
    baud_d    = baud_q;
    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
        tx_d      = 1'b1;
        if (load) begin
          state_d = ST_SEND;
          baud_d  = baud_sel;
          // Everything after the start bit, stop bit in the MSB.
          shreg_d = {1'b1, bit9, bit8, din[6:0]};
          tx_d    = 1'b0;
        end
      end
      ST_SEND: begin
        if (btu) begin
          if (bit_cnt_q == BIT_CNT_W'(FRAME_BITS - 1)) begin
            state_d   = ST_IDLE;
            tx_d      = 1'b1;
            bit_cnt_d = '0;
            shreg_d   = '1;
          end else begin
            tx_d      = shreg_q[0];
            shreg_d   = {1'b1, shreg_q[9:1]};
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '1;
      tx_q      <= 1'b1;
      bit_cnt_q <= '0;
      baud_q    <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
      bit_cnt_q <= bit_cnt_d;
      baud_q    <= baud_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: randomized frames checked by a line monitor against a queue of expected frames.
module tb_uart_tx_engine;
  import uart_pkg::*;

  logic       clk;
  logic       rst;
  logic       load;
  logic [7:0] din;
  logic [3:0] baud_sel;
  logic       eight;
  logic       pen;
  logic       ohel;
  logic       tx;
  logic       txrdy;
  tx_state_e  state_o;

  int  n_checks = 0;
  int  n_errors = 0;
  bit  mon_busy = 0;
  logic [34:0] exp_q[$];

  uart_tx_engine #(.CLK_HZ(100000000)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .din      (din),
    .baud_sel (baud_sel),
    .eight    (eight),
    .pen      (pen),
    .ohel     (ohel),
    .tx       (tx),
    .txrdy    (txrdy),
    .state_o  (state_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  function automatic int model_div(input int sel);
    real rates [12];
    rates = '{300.0, 1200.0, 2400.0, 4800.0, 9600.0, 19200.0, 38400.0,
              57600.0, 115200.0, 230400.0, 460800.0, 921600.0};
    if (sel > 11) sel = 11;
    return $rtoi(100.0e6 / rates[sel] + 0.5);
  endfunction

  function automatic logic [10:0] model_frame(input logic [7:0] d, input logic e,
                                              input logic p, input logic o);
    bit   q[$];
    int   nbits;
    int   ones;
    bit   use_p;
    logic [10:0] f;
`ifdef UART_TX_PARITY_EN
    use_p = p;
`else
    use_p = 1'b0;
`endif
    nbits = e ? 8 : 7;
    ones  = 0;
    q.push_back(1'b0);
    for (int i = 0; i < nbits; i++) begin
      q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (use_p) q.push_back(((ones % 2) == 1) ^ o);
    while (q.size() < 10) q.push_back(1'b1);
    q.push_back(1'b1);
    for (int i = 0; i < 11; i++) f[i] = q[i];
    return f;
  endfunction

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] d, input logic [3:0] bs, input logic e,
                      input logic p, input logic o);
    int t;
    logic [23:0] dv;
    t = 0;
    @(negedge clk);
    while (!txrdy && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (!txrdy) begin
      check(1'b0, "send_wait_rdy", 0, 1);
      return;
    end
    din = d; baud_sel = bs; eight = e; pen = p; ohel = o; load = 1'b1;
    dv = 24'(model_div(int'(bs)));
    exp_q.push_back({dv, model_frame(d, e, p, o)});
    @(negedge clk);
    load = 1'b0;
    check(txrdy === 1'b0 && tx === 1'b0, "start_latency", longint'({txrdy, tx}), 0);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(txrdy === 1'b1 && !mon_busy && exp_q.size() == 0) && t < 20000);
    check(t < 20000, "wait_idle", t, 20000);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic        prev_rdy;
    logic [34:0] e;
    logic [10:0] bits;
    int          div;
    bit          aborted;
    bit          bad;
    logic [1:0]  bad_val;
    int          fnum;
    prev_rdy = 1'b1;
    fnum = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_rdy = 1'b1;
        continue;
      end
      if (prev_rdy && txrdy === 1'b0) begin
        mon_busy = 1'b1;
        check(exp_q.size() != 0, "unexpected_frame", exp_q.size(), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          bits = e[10:0];
          div = int'(e[34:11]);
          aborted = 1'b0;
          for (int b = 0; b < 11; b++) begin
            bad = 1'b0;
            bad_val = 2'b00;
            for (int c = 0; c < div; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (rst) begin
                aborted = 1'b1;
                break;
              end
              if (!bad && (tx !== bits[b] || txrdy !== 1'b0)) begin
                bad = 1'b1;
                bad_val = {txrdy, tx};
              end
            end
            if (aborted) break;
            check(!bad, $sformatf("frame%0d_bit%0d {txrdy,tx}", fnum, b),
                  longint'(bad_val), longint'({1'b0, bits[b]}));
          end
          if (!aborted) begin
            @(negedge clk);
            if (!rst)
              check(tx === 1'b1 && txrdy === 1'b1, $sformatf("frame%0d_end {txrdy,tx}", fnum),
                    longint'({txrdy, tx}), 3);
          end
          fnum++;
        end
        mon_busy = 1'b0;
      end
      prev_rdy = txrdy;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    repeat (150000) @(posedge clk);
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    int bad_cnt;
    rst = 1'b1; load = 1'b0; din = '0; baud_sel = 4'd8; eight = 1'b1; pen = 1'b0; ohel = 1'b0;
    #1;
    check(tx === 1'b1, "reset_tx", longint'(tx), 1);
    check(txrdy === 1'b1, "reset_txrdy", longint'(txrdy), 1);
    check(state_o === ST_IDLE, "reset_state", longint'(state_o), longint'(ST_IDLE));
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 8N1 at 115200: 868 clocks per bit
    send(8'hA5, 4'd8, 1'b1, 1'b0, 1'b0);
    wait_idle();

    // 7-bit with odd then even parity, back to back
    send(8'h41, 4'd15, 1'b0, 1'b1, 1'b1);
    send(8'h41, 4'd15, 1'b0, 1'b1, 1'b0);
    send(8'h01, 4'd12, 1'b1, 1'b1, 1'b0);
    wait_idle();

    // load while busy must be ignored
    send(8'hA5, 4'd8, 1'b1, 1'b0, 1'b0);
    repeat (3000) @(negedge clk);
    din = 8'hFF; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_idle();
    bad_cnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1 || txrdy !== 1'b1) bad_cnt++;
    end
    check(bad_cnt == 0, "no_second_frame", bad_cnt, 0);

    // inputs changed mid-frame must not disturb the frame in flight
    send(8'hA5, 4'd8, 1'b1, 1'b0, 1'b0);
    repeat (2000) @(negedge clk);
    baud_sel = 4'd11; din = 8'h3C; eight = 1'b0; pen = 1'b1; ohel = 1'b1;
    wait_idle();
    send(8'h5A, 4'd11, 1'b1, 1'b0, 1'b0);
    wait_idle();

    // randomized frames, mixing back-to-back and gapped starts
    for (int i = 0; i < 12; i++) begin
      send(8'($urandom), 4'($urandom_range(10, 15)), 1'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        wait_idle();
        repeat ($urandom_range(0, 30)) @(negedge clk);
      end
    end
    wait_idle();

    // reset during bit 4 aborts the frame
    send(8'h01, 4'd15, 1'b1, 1'b1, 1'b0);
    repeat (4 * 109 + 40) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check(tx === 1'b1, "async_rst_tx", longint'(tx), 1);
    check(txrdy === 1'b1, "async_rst_txrdy", longint'(txrdy), 1);
    repeat (3) @(negedge clk);
    exp_q.delete();
    rst = 1'b0;
    bad_cnt = 0;
    repeat (2 * 11 * 109) begin
      @(negedge clk);
      if (tx !== 1'b1 || txrdy !== 1'b1) bad_cnt++;
    end
    check(bad_cnt == 0, "post_reset_idle", bad_cnt, 0);

    // engine still usable after the abort
    send(8'hC3, 4'd13, 1'b1, 1'b1, 1'b1);
    wait_idle();
    check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
